// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Holds the FSM state encoding, CSR addresses, interrupt cause codes and mstatus helpers.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
    WR_STATUS,
    MRET_STATUS,
    REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // MPP is always forced to machine mode (bits 12:11) since only M-mode exists here.
  function automatic logic [31:0] status_on_trap(input logic prev_mie);
    logic [31:0] value;
    value        = 32'd0;
    value[12:11] = 2'b11;
    value[7]     = prev_mie;
    value[3]     = 1'b0;
    return value;
  endfunction

  function automatic logic [31:0] status_on_mret(input logic prev_mpie);
    logic [31:0] value;
    value        = 32'd0;
    value[12:11] = 2'b11;
    value[7]     = 1'b1;
    value[3]     = prev_mpie;
    return value;
  endfunction

endpackage

// File: rtl/trap_prio.sv
// Masked machine-interrupt priority encoder.
// Picks the highest-priority enabled and pending source: MEI, then MSI, then MTI.
module trap_prio
  import trap_pkg::*;
(
  input  logic       global_en,
  input  logic       msie,
  input  logic       mtie,
  input  logic       meie,
  input  logic       msip,
  input  logic       mtip,
  input  logic       meip,
  output logic       irq_valid,
  output logic [3:0] irq_code
);

  always_comb begin
    irq_valid = 1'b0;
    irq_code  = 4'd0;
    if (global_en) begin
      if (meie && meip) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MEI;
      end else if (msie && msip) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MSI;
      end else if (mtie && mtip) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: serialises mepc/mcause/mstatus writes then redirects the core.
// Define TRAP_VECTORED_EN to let mtvec MODE==1 vector interrupts to BASE + 4*code.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        instr_boundary,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic        mret_valid,
  input  logic        mstatus_MIE,
  input  logic        mstatus_MPIE,
  input  logic        mie_MSIE,
  input  logic        mie_MTIE,
  input  logic        mie_MEIE,
  input  logic        mip_MSIP,
  input  logic        mip_MTIP,
  input  logic        mip_MEIP,
  input  logic [1:0]  mtvec_MODE,
  input  logic [29:0] mtvec_BASE,
  input  logic [31:0] mepc_REG,
  output logic        csr_WE_L,
  output logic [11:0] csr_address,
  output logic [31:0] csr_write_data,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_lat_q, mie_lat_d;
  logic        mpie_lat_q, mpie_lat_d;
  logic [31:0] target_q, target_d;

  logic        csr_we_l_q, csr_we_l_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_data_q, csr_data_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        irq_valid;
  logic [3:0]  irq_code;
  logic        accept_exc;
  logic        accept_irq;
  logic        accept_mret;
  logic        accept;
  logic [31:0] trap_base;
  logic [31:0] vec_target;
  logic [31:0] irq_target;

  trap_prio u_prio (
    .global_en (mstatus_MIE),
    .msie      (mie_MSIE),
    .mtie      (mie_MTIE),
    .meie      (mie_MEIE),
    .msip      (mip_MSIP),
    .mtip      (mip_MTIP),
    .meip      (mip_MEIP),
    .irq_valid (irq_valid),
    .irq_code  (irq_code)
  );

  assign accept_exc  = (state_q == IDLE) && exc_valid;
  assign accept_irq  = (state_q == IDLE) && !exc_valid && irq_valid && instr_boundary;
  assign accept_mret = (state_q == IDLE) && !exc_valid && !(irq_valid && instr_boundary)
                       && mret_valid;
  assign accept      = accept_exc || accept_irq || accept_mret;

  assign trap_base  = {mtvec_BASE, 2'b00};
  assign vec_target = trap_base + {26'd0, irq_code, 2'b00};

`ifdef TRAP_VECTORED_EN
  assign irq_target = (mtvec_MODE == 2'b01) ? vec_target : trap_base;
`else
  logic unused_vector_cfg;
  assign unused_vector_cfg = ^{mtvec_MODE, vec_target};
  assign irq_target        = trap_base;
`endif

  // Next-state and latch capture; latches only move when a request is taken in IDLE.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    mie_lat_d  = mie_lat_q;
    mpie_lat_d = mpie_lat_q;
    target_d   = target_q;
    case (state_q)
      IDLE: begin
        if (accept_exc) begin
          pc_d      = pc;
          cause_d   = {1'b0, 27'd0, exc_code};
          mie_lat_d = mstatus_MIE;
          target_d  = trap_base;
          state_d   = WR_EPC;
        end else if (accept_irq) begin
          pc_d      = pc;
          cause_d   = {1'b1, 27'd0, irq_code};
          mie_lat_d = mstatus_MIE;
          target_d  = irq_target;
          state_d   = WR_EPC;
        end else if (accept_mret) begin
          mpie_lat_d = mstatus_MPIE;
          target_d   = mepc_REG;
          state_d    = MRET_STATUS;
        end
      end
      WR_EPC:      state_d = WR_CAUSE;
      WR_CAUSE:    state_d = WR_STATUS;
      WR_STATUS:   state_d = REDIRECT;
      MRET_STATUS: state_d = REDIRECT;
      REDIRECT:    state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    csr_we_l_d       = 1'b1;
    csr_addr_d       = 12'd0;
    csr_data_d       = 32'd0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = 32'd0;
    case (state_d)
      WR_EPC: begin
        csr_we_l_d = 1'b0;
        csr_addr_d = CSR_MEPC;
        csr_data_d = pc_d;
      end
      WR_CAUSE: begin
        csr_we_l_d = 1'b0;
        csr_addr_d = CSR_MCAUSE;
        csr_data_d = cause_d;
      end
      WR_STATUS: begin
        csr_we_l_d = 1'b0;
        csr_addr_d = CSR_MSTATUS;
        csr_data_d = status_on_trap(mie_lat_d);
      end
      MRET_STATUS: begin
        csr_we_l_d = 1'b0;
        csr_addr_d = CSR_MSTATUS;
        csr_data_d = status_on_mret(mpie_lat_d);
      end
      REDIRECT: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      pc_q             <= 32'd0;
      cause_q          <= 32'd0;
      mie_lat_q        <= 1'b0;
      mpie_lat_q       <= 1'b0;
      target_q         <= 32'd0;
      csr_we_l_q       <= 1'b1;
      csr_addr_q       <= 12'd0;
      csr_data_q       <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      cause_q          <= cause_d;
      mie_lat_q        <= mie_lat_d;
      mpie_lat_q       <= mpie_lat_d;
      target_q         <= target_d;
      csr_we_l_q       <= csr_we_l_d;
      csr_addr_q       <= csr_addr_d;
      csr_data_q       <= csr_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign csr_WE_L       = csr_we_l_q;
  assign csr_address    = csr_addr_q;
  assign csr_write_data = csr_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall          = (state_q != IDLE) || accept;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of trap/MRET transactions plus reset and masking sequences.
// Expected redirect targets follow TRAP_VECTORED_EN when it is defined for the build.
module tb_trap_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        instr_boundary;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic        mret_valid;
  logic        mstatus_MIE;
  logic        mstatus_MPIE;
  logic        mie_MSIE;
  logic        mie_MTIE;
  logic        mie_MEIE;
  logic        mip_MSIP;
  logic        mip_MTIP;
  logic        mip_MEIP;
  logic [1:0]  mtvec_MODE;
  logic [29:0] mtvec_BASE;
  logic [31:0] mepc_REG;
  logic        csr_WE_L;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests_run;
  int tests_failed;

  trap_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .instr_boundary (instr_boundary),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .mret_valid     (mret_valid),
    .mstatus_MIE    (mstatus_MIE),
    .mstatus_MPIE   (mstatus_MPIE),
    .mie_MSIE       (mie_MSIE),
    .mie_MTIE       (mie_MTIE),
    .mie_MEIE       (mie_MEIE),
    .mip_MSIP       (mip_MSIP),
    .mip_MTIP       (mip_MTIP),
    .mip_MEIP       (mip_MEIP),
    .mtvec_MODE     (mtvec_MODE),
    .mtvec_BASE     (mtvec_BASE),
    .mepc_REG       (mepc_REG),
    .csr_WE_L       (csr_WE_L),
    .csr_address    (csr_address),
    .csr_write_data (csr_write_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXP_MTI_TARGET = 32'h0000_081C;
  localparam logic [31:0] EXP_MSI_TARGET = 32'h0000_080C;
`else
  localparam logic [31:0] EXP_MTI_TARGET = 32'h0000_0800;
  localparam logic [31:0] EXP_MSI_TARGET = 32'h0000_0800;
`endif

  // Enables and pendings are packed as {MEI, MTI, MSI}.
  typedef struct {
    logic [31:0] pc;
    logic        boundary;
    logic        exc_v;
    logic [3:0]  exc_c;
    logic        mret_v;
    logic        mie;
    logic        mpie;
    logic [2:0]  en;
    logic [2:0]  pend;
    logic [1:0]  mode;
    logic [29:0] base;
    logic [31:0] mepc;
    logic        exp_mret;
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
    logic [31:0] exp_status;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(
    input logic [31:0] v_pc, input logic v_bnd, input logic v_exc, input logic [3:0] v_code,
    input logic v_mret, input logic v_mie, input logic v_mpie, input logic [2:0] v_en,
    input logic [2:0] v_pend, input logic [1:0] v_mode, input logic [29:0] v_base,
    input logic [31:0] v_mepc, input logic e_mret, input logic [31:0] e_epc,
    input logic [31:0] e_cause, input logic [31:0] e_status, input logic [31:0] e_target);
    vec_t v;
    v.pc = v_pc; v.boundary = v_bnd; v.exc_v = v_exc; v.exc_c = v_code;
    v.mret_v = v_mret; v.mie = v_mie; v.mpie = v_mpie; v.en = v_en; v.pend = v_pend;
    v.mode = v_mode; v.base = v_base; v.mepc = v_mepc;
    v.exp_mret = e_mret; v.exp_epc = e_epc; v.exp_cause = e_cause;
    v.exp_status = e_status; v.exp_target = e_target;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    pc = 32'd0; instr_boundary = 1'b0; exc_valid = 1'b0; exc_code = 4'd0;
    mret_valid = 1'b0; mstatus_MIE = 1'b0; mstatus_MPIE = 1'b0;
    mie_MSIE = 1'b0; mie_MTIE = 1'b0; mie_MEIE = 1'b0;
    mip_MSIP = 1'b0; mip_MTIP = 1'b0; mip_MEIP = 1'b0;
    mtvec_MODE = 2'd0; mtvec_BASE = 30'd0; mepc_REG = 32'd0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    pc = v.pc; instr_boundary = v.boundary; exc_valid = v.exc_v; exc_code = v.exc_c;
    mret_valid = v.mret_v; mstatus_MIE = v.mie; mstatus_MPIE = v.mpie;
    {mie_MEIE, mie_MTIE, mie_MSIE} = v.en;
    {mip_MEIP, mip_MTIP, mip_MSIP} = v.pend;
    mtvec_MODE = v.mode; mtvec_BASE = v.base; mepc_REG = v.mepc;
  endtask

  task automatic check_write(input string name, input logic [11:0] addr,
                             input logic [31:0] data);
    check_output({name, "_we_l"}, {31'd0, csr_WE_L}, 32'd0);
    check_output({name, "_addr"}, {20'd0, csr_address}, {20'd0, addr});
    check_output({name, "_data"}, csr_write_data, data);
    check_output({name, "_stall"}, {31'd0, stall}, 32'd1);
    check_output({name, "_no_redirect"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    @(negedge clock);
    apply_stimulus(v);
    #1;
    check_output("accept_stall", {31'd0, stall}, 32'd1);
    check_output("accept_no_write", {31'd0, csr_WE_L}, 32'd1);
    @(negedge clock);
    clear_inputs();
    #1;
    if (v.exp_mret) begin
      check_write("mret_status", 12'h300, v.exp_status);
    end else begin
      check_write("wr_epc", 12'h341, v.exp_epc);
      @(negedge clock); #1;
      check_write("wr_cause", 12'h342, v.exp_cause);
      @(negedge clock); #1;
      check_write("wr_status", 12'h300, v.exp_status);
    end
    @(negedge clock); #1;
    check_output("redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check_output("redirect_pc", redirect_pc, v.exp_target);
    check_output("redirect_no_write", {31'd0, csr_WE_L}, 32'd1);
    @(negedge clock); #1;
    check_output("after_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_output("after_redirect_stall", {31'd0, stall}, 32'd0);
    check_output("after_redirect_we_l", {31'd0, csr_WE_L}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, "_we_l"}, {31'd0, csr_WE_L}, 32'd1);
    check_output({name, "_addr"}, {20'd0, csr_address}, 32'd0);
    check_output({name, "_data"}, csr_write_data, 32'd0);
    check_output({name, "_stall"}, {31'd0, stall}, 32'd0);
    check_output({name, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    check_output({name, "_rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //         pc      bnd exc code mret mie mpie en      pend    mode base    mepc
    //         exp_mret epc     cause          status    target
    vecs[0] = mk(32'h100, 0, 1, 4'd2, 0, 1, 0, 3'b000, 3'b000, 2'd0, 30'h200, 32'h0,
                 0, 32'h100, 32'h0000_0002, 32'h1880, 32'h800);
    vecs[1] = mk(32'h204, 1, 0, 4'd0, 0, 1, 0, 3'b110, 3'b110, 2'd0, 30'h200, 32'h0,
                 0, 32'h204, 32'h8000_000B, 32'h1880, 32'h800);
    vecs[2] = mk(32'h040, 1, 0, 4'd0, 0, 1, 0, 3'b010, 3'b010, 2'd1, 30'h200, 32'h0,
                 0, 32'h040, 32'h8000_0007, 32'h1880, EXP_MTI_TARGET);
    vecs[3] = mk(32'h0, 0, 0, 4'd0, 1, 0, 1, 3'b000, 3'b000, 2'd0, 30'h200, 32'h3000,
                 1, 32'h0, 32'h0, 32'h1888, 32'h3000);
    vecs[4] = mk(32'h088, 0, 1, 4'd5, 1, 0, 1, 3'b000, 3'b000, 2'd0, 30'h300, 32'h4444,
                 0, 32'h088, 32'h0000_0005, 32'h1800, 32'hC00);
    vecs[5] = mk(32'h060, 1, 0, 4'd0, 0, 1, 0, 3'b011, 3'b011, 2'd1, 30'h200, 32'h0,
                 0, 32'h060, 32'h8000_0003, 32'h1880, EXP_MSI_TARGET);
    vecs[6] = mk(32'h0, 0, 0, 4'd0, 1, 1, 0, 3'b000, 3'b000, 2'd0, 30'h200, 32'h1234,
                 1, 32'h0, 32'h0, 32'h1880, 32'h1234);
    vecs[7] = mk(32'h0AC, 0, 1, 4'd2, 0, 1, 0, 3'b000, 3'b000, 2'd1, 30'h200, 32'h0,
                 0, 32'h0AC, 32'h0000_0002, 32'h1880, 32'h800);
    vecs[8] = mk(32'h070, 0, 0, 4'd0, 1, 1, 1, 3'b010, 3'b010, 2'd0, 30'h200, 32'h500,
                 1, 32'h0, 32'h0, 32'h1888, 32'h500);

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      $display("[TB] vector %0d", i);
      run_vector(vecs[i]);
    end

    // Globally masked timer interrupt at a boundary must not be taken.
    @(negedge clock);
    clear_inputs();
    mstatus_MIE = 1'b0; mie_MTIE = 1'b1; mip_MTIP = 1'b1; instr_boundary = 1'b1;
    mtvec_BASE = 30'h200;
    #1;
    check_output("masked_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      check_output("masked_idle", {30'd0, csr_WE_L, redirect_valid}, 32'd2);
      check_output("masked_stall_hold", {31'd0, stall}, 32'd0);
    end
    clear_inputs();

    // Reset landing while in WR_CAUSE abandons the sequence.
    @(negedge clock);
    apply_stimulus(vecs[0]);
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    #1;
    check_write("pre_reset_cause", 12'h342, 32'h0000_0002);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      check_output("post_reset_quiet", {30'd0, csr_WE_L, redirect_valid}, 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
